output_port_allocator: RTL and testbench
========================================

OUTPUT_PORT_ALLOCATOR -- requirements
Module: output_port_allocator

Interface
REQ-001 The block SHALL have parameter NUM_INPUTS, default 5: number of requesting router input ports; index 0 is the local port.
REQ-002 The block SHALL have parameter FLIT_BUFFER_DEPTH, default 2: downstream buffer depth in flits, which is the initial credit count.
REQ-003 The block SHALL have parameter CREDIT_WIDTH, default $clog2(FLIT_BUFFER_DEPTH+1): width of the credit counter.
REQ-004 The block SHALL have port clk_noc, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_noc_sync, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port req, input, [0:NUM_INPUTS-1]: input i has a flit at its buffer head routed to this output.
REQ-007 The block SHALL have port req_is_tail, input, [0:NUM_INPUTS-1]: the requesting flit of input i is a tail flit.
REQ-008 The block SHALL have port turn_disable, input, [0:NUM_INPUTS-1]: input i is forbidden to use this output (a DISABLE_TURNS column).
REQ-009 The block SHALL have port grant, output, [0:NUM_INPUTS-1]: one-hot or zero; input i's flit transfers this cycle.
REQ-010 The block SHALL have port send_out, output, 1 bit: OR of grant; the flit is launched downstream.
REQ-011 The block SHALL have port credit_in, input, 1 bit: the downstream buffer freed one slot.
REQ-012 The block SHALL have port credits, output, CREDIT_WIDTH bits: current credit count.
REQ-013 The block SHALL have port locked, output, 1 bit: state is LOCKED.
REQ-014 The block SHALL have port owner, output, $clog2(NUM_INPUTS) bits: index of the input holding the lock; valid when locked=1.
REQ-015 The block SHALL have port credit_err, output, 1 bit: sticky flag set by a credit overflow.

Function
REQ-016 The block SHALL implement a two-state FSM with states IDLE and LOCKED (wormhole allocation).
REQ-017 Eligibility: input i SHALL be eligible when req[i]=1 and turn_disable[i]=0; disabled inputs are never granted.
REQ-018 In IDLE with credits>0, grant SHALL be driven combinationally, in the same cycle, to the first eligible input searching rr_ptr+1, rr_ptr+2, ... with modulo-NUM_INPUTS wrap-around.
REQ-019 In IDLE with credits=0 or no eligible input, grant SHALL be all zeros.
REQ-020 On an IDLE grant to input w, rr_ptr SHALL become w; if req_is_tail[w]=0 the FSM SHALL go to LOCKED with owner=w; if req_is_tail[w]=1 (single-flit packet) the FSM SHALL stay in IDLE.
REQ-021 In LOCKED, grant[owner] SHALL equal req[owner] AND credits>0, and all other grant bits SHALL be 0 regardless of their requests.
REQ-022 The turn_disable bit SHALL NOT be re-checked in LOCKED.
REQ-023 In LOCKED, a grant with req_is_tail[owner]=1 SHALL return the FSM to IDLE on the next edge, and rr_ptr SHALL be unchanged.
REQ-024 Credit counter update: send_out only -> credits-1; credit_in only -> credits+1; both in the same cycle -> unchanged.
REQ-025 credits SHALL never underflow; this is guaranteed by REQ-018, REQ-019 and REQ-021.
REQ-026 A credit_in with credits=FLIT_BUFFER_DEPTH and send_out=0 SHALL saturate the counter and set credit_err, which stays set until reset.
REQ-027 Latency: a request with credits available SHALL be granted in the same cycle (zero-cycle allocation); throughput SHALL be one flit per cycle while credits>0.

Reset
REQ-028 When rst_noc_sync=1 at an edge, the block SHALL reset to: state IDLE, owner=0, rr_ptr=NUM_INPUTS-1 (so input 0 has first priority), credits=FLIT_BUFFER_DEPTH, credit_err=0.
REQ-029 While rst_noc_sync=1, grant and send_out SHALL be forced to 0.
REQ-030 A reset in mid-packet SHALL drop the lock unconditionally, with no tail flit required.

Verification
REQ-031 The bench SHALL cover these directed scenarios, with NUM_INPUTS=5 and DEPTH=2:
- After reset, req=5'b11111 with all tails set, credit_in pulsed every cycle -> grants in order 0,1,2,3,4,0; credits stays 2; credit_err=0.
- Input 2 sends a 4-flit packet while inputs 1 and 3 also request -> grant[2] for all 4 flits; locked=1 from the head edge to the tail edge; the next grant goes to 3.
- Single request, no credit_in -> 2 grants, then credits=0 and grant=0; one credit_in -> exactly one further grant.
- Send and credit_in in the same cycle with credits=1 -> credits stays 1.
- turn_disable[1]=1, req=5'b01000 -> no grant ever; credits stay 2.
- Reset asserted after the head flit of a 3-flit packet -> locked=0 and credits=2 next cycle; a new request from a different input is granted immediately.
- credit_in while credits=2 -> credits stays 2 and credit_err=1 until the next reset.

Source files
------------

// File: rtl/output_port_allocator.sv
// Wormhole output-port allocator: round-robin arbitration across router inputs,
// lock held from head to tail flit, credit-based flow control toward downstream.
module output_port_allocator #(
    parameter int NUM_INPUTS        = 5,
    parameter int FLIT_BUFFER_DEPTH = 2,
    parameter int CREDIT_WIDTH      = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
    input  logic                          clk_noc,
    input  logic                          rst_noc_sync,
    input  logic [0:NUM_INPUTS-1]         req,
    input  logic [0:NUM_INPUTS-1]         req_is_tail,
    input  logic [0:NUM_INPUTS-1]         turn_disable,
    output logic [0:NUM_INPUTS-1]         grant,
    output logic                          send_out,
    input  logic                          credit_in,
    output logic [CREDIT_WIDTH-1:0]       credits,
    output logic                          locked,
    output logic [$clog2(NUM_INPUTS)-1:0] owner,
    output logic                          credit_err
);

    localparam int IDX_W = $clog2(NUM_INPUTS);
    localparam logic [CREDIT_WIDTH-1:0] CRED_MAX = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);
    localparam logic [CREDIT_WIDTH-1:0] CRED_ONE = CREDIT_WIDTH'(1);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        owner_q, owner_d;
    logic [IDX_W-1:0]        rr_q, rr_d;
    logic [CREDIT_WIDTH-1:0] credits_q, credits_d;
    logic                    err_q, err_d;

    logic [0:NUM_INPUTS-1]   elig;
    logic                    found;
    logic [IDX_W-1:0]        win;
    logic                    have_credit;

    assign elig        = req & ~turn_disable;
    assign have_credit = (credits_q != '0);

    // Round-robin search starting just after the last IDLE winner.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        win   = '0;
        for (int k = 1; k <= NUM_INPUTS; k++) begin
            idx = (int'(rr_q) + k) % NUM_INPUTS;
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = IDX_W'(idx);
            end
        end
    end

    always_comb begin
        grant   = '0;
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        case (state_q)
            IDLE: begin
                if (have_credit && found) begin
                    grant[win] = 1'b1;
                    rr_d       = win;
                    if (!req_is_tail[win]) begin
                        state_d = LOCKED;
                        owner_d = win;
                    end
                end
            end
            LOCKED: begin
                // The turn restriction was already honoured when the head flit won.
                if (req[owner_q] && have_credit) begin
                    grant[owner_q] = 1'b1;
                    if (req_is_tail[owner_q]) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst_noc_sync) grant = '0;
    end

    assign send_out = |grant;

    always_comb begin
        credits_d = credits_q;
        err_d     = err_q;
        if (send_out && !credit_in) begin
            credits_d = credits_q - CRED_ONE;
        end else if (credit_in && !send_out) begin
            if (credits_q == CRED_MAX) err_d = 1'b1;
            else                       credits_d = credits_q + CRED_ONE;
        end
    end

    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            rr_q      <= IDX_W'(NUM_INPUTS - 1);
            credits_q <= CRED_MAX;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_q      <= rr_d;
            credits_q <= credits_d;
            err_q     <= err_d;
        end
    end

    assign credits    = credits_q;
    assign locked     = (state_q == LOCKED);
    assign owner      = owner_q;
    assign credit_err = err_q;

endmodule

// File: tb/tb_output_port_allocator.sv
// Directed scenarios for output_port_allocator with a grant scoreboard:
// expected winners are queued as stimulus is planned and popped on each send.
module tb_output_port_allocator;

    localparam int N = 5;

    logic         clk_noc = 1'b0;
    logic         rst_noc_sync = 1'b1;
    logic [0:N-1] req = '0;
    logic [0:N-1] req_is_tail = '0;
    logic [0:N-1] turn_disable = '0;
    logic [0:N-1] grant;
    logic         send_out;
    logic         credit_in = 1'b0;
    logic [1:0]   credits;
    logic         locked;
    logic [2:0]   owner;
    logic         credit_err;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_q[$];

    output_port_allocator #(.NUM_INPUTS(N), .FLIT_BUFFER_DEPTH(2)) dut (
        .clk_noc(clk_noc), .rst_noc_sync(rst_noc_sync),
        .req(req), .req_is_tail(req_is_tail), .turn_disable(turn_disable),
        .grant(grant), .send_out(send_out), .credit_in(credit_in),
        .credits(credits), .locked(locked), .owner(owner), .credit_err(credit_err)
    );

    always #5 clk_noc = ~clk_noc;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int gidx(input logic [0:N-1] g);
        int r;
        int cnt;
        r = -1;
        cnt = 0;
        for (int i = 0; i < N; i++) if (g[i]) begin r = i; cnt++; end
        if (cnt > 1) r = -2;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk_noc);
        #1;
    endtask

    task automatic do_reset();
        rst_noc_sync = 1'b1;
        req = '0; req_is_tail = '0; turn_disable = '0; credit_in = 1'b0;
        exp_q.delete();
        tick();
        rst_noc_sync = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        req = 5'b11111; req_is_tail = 5'b11111;
        #3;
        n_checks++;
        if (grant !== 5'b00000 || send_out !== 1'b0)
            $display("FAIL reset_grant: grant=%b send_out=%b, required 00000/0", grant, send_out);
        else n_pass++;
        tick();
        rst_noc_sync = 1'b0; req = '0;
        #3;
        n_checks++;
        if (credits !== 2'd2 || locked !== 1'b0 || credit_err !== 1'b0 || owner !== 3'd0)
            $display("FAIL reset_state: credits=%0d locked=%b err=%b owner=%0d, required 2/0/0/0",
                     credits, locked, credit_err, owner);
        else n_pass++;
        tick();
    endtask

    task automatic test_round_robin();
        int e;
        do_reset();
        exp_q = '{0, 1, 2, 3, 4, 0};
        for (int c = 0; c < 6; c++) begin
            req = 5'b11111; req_is_tail = 5'b11111; credit_in = 1'b1;
            #3;
            n_checks++;
            if (!send_out) $display("FAIL rr_send cycle %0d: send_out=0, required 1", c);
            else if (exp_q.size() == 0) $display("FAIL rr_extra cycle %0d: grant %0d unexpected", c, gidx(grant));
            else begin
                e = exp_q.pop_front();
                if (gidx(grant) !== e) $display("FAIL rr_order cycle %0d: grant=%0d required %0d", c, gidx(grant), e);
                else n_pass++;
            end
            n_checks++;
            if (credits !== 2'd2) $display("FAIL rr_credits cycle %0d: credits=%0d required 2", c, credits);
            else n_pass++;
            tick();
        end
        req = '0; credit_in = 1'b0;
        #3;
        n_checks++;
        if (credits !== 2'd2 || credit_err !== 1'b0)
            $display("FAIL rr_final: credits=%0d err=%b required 2/0", credits, credit_err);
        else n_pass++;
    endtask

    task automatic test_wormhole();
        logic [0:N-1] t_req [6];
        logic [0:N-1] t_tail [6];
        logic         t_lock [6];
        int e;
        do_reset();
        t_req  = '{5'b01000, 5'b01110, 5'b01110, 5'b01110, 5'b01110, 5'b01010};
        t_tail = '{5'b11111, 5'b11011, 5'b11011, 5'b11011, 5'b11111, 5'b11111};
        t_lock = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_q  = '{1, 2, 2, 2, 2, 3};
        for (int c = 0; c < 6; c++) begin
            req = t_req[c]; req_is_tail = t_tail[c]; credit_in = 1'b1;
            #3;
            n_checks++;
            if (!send_out) $display("FAIL worm_send cycle %0d: send_out=0, required 1", c);
            else if (exp_q.size() == 0) $display("FAIL worm_extra cycle %0d: grant %0d unexpected", c, gidx(grant));
            else begin
                e = exp_q.pop_front();
                if (gidx(grant) !== e) $display("FAIL worm_grant cycle %0d: grant=%0d required %0d", c, gidx(grant), e);
                else n_pass++;
            end
            n_checks++;
            if (locked !== t_lock[c]) $display("FAIL worm_locked cycle %0d: locked=%b required %b", c, locked, t_lock[c]);
            else n_pass++;
            if (t_lock[c]) begin
                n_checks++;
                if (owner !== 3'd2) $display("FAIL worm_owner cycle %0d: owner=%0d required 2", c, owner);
                else n_pass++;
            end
            tick();
        end
        req = '0; credit_in = 1'b0;
        #3;
        n_checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL worm_missing: %0d grants outstanding, required 0", exp_q.size());
            exp_q.delete();
        end else n_pass++;
    endtask

    task automatic test_credit_exhaust();
        logic       t_cin [6];
        logic       t_send [6];
        logic [1:0] t_cred [6];
        int e;
        do_reset();
        t_cin  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        t_send = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        t_cred = '{2'd2, 2'd1, 2'd0, 2'd0, 2'd1, 2'd0};
        exp_q  = '{0, 0, 0};
        for (int c = 0; c < 6; c++) begin
            req = 5'b10000; req_is_tail = 5'b11111; credit_in = t_cin[c];
            #3;
            n_checks++;
            if (send_out !== t_send[c] || (!t_send[c] && grant !== 5'b00000))
                $display("FAIL cred_send cycle %0d: send_out=%b grant=%b required send %b", c, send_out, grant, t_send[c]);
            else n_pass++;
            n_checks++;
            if (credits !== t_cred[c]) $display("FAIL cred_count cycle %0d: credits=%0d required %0d", c, credits, t_cred[c]);
            else n_pass++;
            if (send_out) begin
                n_checks++;
                if (exp_q.size() == 0) $display("FAIL cred_extra cycle %0d: grant %0d unexpected", c, gidx(grant));
                else begin
                    e = exp_q.pop_front();
                    if (gidx(grant) !== e) $display("FAIL cred_grant cycle %0d: grant=%0d required %0d", c, gidx(grant), e);
                    else n_pass++;
                end
            end
            tick();
        end
        req = '0; credit_in = 1'b0;
        n_checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL cred_missing: %0d grants outstanding, required 0", exp_q.size());
            exp_q.delete();
        end else n_pass++;
    endtask

    task automatic test_send_and_credit();
        do_reset();
        req = 5'b10000; req_is_tail = 5'b11111;
        tick();
        credit_in = 1'b1;
        #3;
        n_checks++;
        if (credits !== 2'd1 || send_out !== 1'b1)
            $display("FAIL both_pre: credits=%0d send_out=%b required 1/1", credits, send_out);
        else n_pass++;
        tick();
        req = '0; credit_in = 1'b0;
        #3;
        n_checks++;
        if (credits !== 2'd1) $display("FAIL both_hold: credits=%0d required 1", credits);
        else n_pass++;
        tick();
    endtask

    task automatic test_turn_disable();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            turn_disable = 5'b01000; req = 5'b01000; req_is_tail = 5'b11111;
            #3;
            n_checks++;
            if (grant !== 5'b00000 || send_out !== 1'b0 || credits !== 2'd2)
                $display("FAIL turn_block cycle %0d: grant=%b send_out=%b credits=%0d required 00000/0/2",
                         c, grant, send_out, credits);
            else n_pass++;
            tick();
        end
        turn_disable = '0; req = '0;
    endtask

    task automatic test_reset_mid_packet();
        int e;
        do_reset();
        exp_q = '{0, 3};
        req = 5'b10000; req_is_tail = 5'b00000;
        #3;
        n_checks++;
        if (!send_out) $display("FAIL mid_head: send_out=0, required 1");
        else begin
            e = exp_q.pop_front();
            if (gidx(grant) !== e) $display("FAIL mid_head: grant=%0d required %0d", gidx(grant), e);
            else n_pass++;
        end
        tick();
        rst_noc_sync = 1'b1;
        #3;
        n_checks++;
        if (locked !== 1'b1 || grant !== 5'b00000)
            $display("FAIL mid_inreset: locked=%b grant=%b required 1/00000", locked, grant);
        else n_pass++;
        tick();
        rst_noc_sync = 1'b0;
        req = 5'b00010; req_is_tail = 5'b11111;
        #3;
        n_checks++;
        if (locked !== 1'b0 || credits !== 2'd2)
            $display("FAIL mid_after: locked=%b credits=%0d required 0/2", locked, credits);
        else n_pass++;
        n_checks++;
        if (!send_out) $display("FAIL mid_new: send_out=0, required 1");
        else begin
            e = exp_q.pop_front();
            if (gidx(grant) !== e) $display("FAIL mid_new: grant=%0d required %0d", gidx(grant), e);
            else n_pass++;
        end
        tick();
        req = '0;
        exp_q.delete();
    endtask

    task automatic test_credit_overflow();
        do_reset();
        credit_in = 1'b1;
        #3;
        n_checks++;
        if (credits !== 2'd2 || credit_err !== 1'b0)
            $display("FAIL ovf_pre: credits=%0d err=%b required 2/0", credits, credit_err);
        else n_pass++;
        tick();
        credit_in = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #3;
            n_checks++;
            if (credits !== 2'd2 || credit_err !== 1'b1)
                $display("FAIL ovf_sticky cycle %0d: credits=%0d err=%b required 2/1", c, credits, credit_err);
            else n_pass++;
            tick();
        end
        rst_noc_sync = 1'b1;
        tick();
        rst_noc_sync = 1'b0;
        #3;
        n_checks++;
        if (credit_err !== 1'b0) $display("FAIL ovf_clear: err=%b required 0", credit_err);
        else n_pass++;
        tick();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_wormhole();
        test_credit_exhaust();
        test_send_and_credit();
        test_turn_disable();
        test_reset_mid_packet();
        test_credit_overflow();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
